// File: rtl/bitstream_scheduler.sv
// Round-robin front end that serialises words from two requesters through one shared
// serial detector, counts its nonzero responses and reports one result per word.
module bitstream_scheduler #(
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 4,
  parameter int DET_LAT = 1,
  parameter int CLR_EN  = 1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             x_in,
  output logic             det_reset,
  input  logic [1:0]       det_out,
  output logic             res_valid,
  output logic             res_id,
  output logic [CNT_W-1:0] res_hits,
  output logic [1:0]       res_last,
  output logic             busy
);

  localparam int TW = $clog2(WIDTH + DET_LAT + 1);
  localparam logic [TW-1:0] LAST_SHIFT  = TW'(WIDTH - 1);
  localparam logic [TW-1:0] LAST_SAMPLE = TW'(WIDTH + DET_LAT - 1);

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             id_q, id_d;
  logic [CNT_W-1:0] hits_q, hits_d;
  logic             rr_q, rr_d;
  logic             x_in_q, x_in_d;
  logic             det_reset_q, det_reset_d;
  logic             res_valid_q, res_valid_d;
  logic             res_id_q, res_id_d;
  logic [CNT_W-1:0] res_hits_q, res_hits_d;
  logic [1:0]       res_last_q, res_last_d;

  logic             idle, grant0, grant1, hs0, hs1, hs, sample;
  logic [WIDTH-1:0] hs_data;

  // rr_q remembers the last granted requester; a tie goes to the other one.
  assign idle   = (state_q == IDLE);
  assign grant0 = req0_valid & (~req1_valid | rr_q);
  assign grant1 = req1_valid & (~req0_valid | ~rr_q);
  assign req0_ready = idle & grant0 & reset;
  assign req1_ready = idle & grant1 & reset;
  assign hs0     = req0_valid & req0_ready;
  assign hs1     = req1_valid & req1_ready;
  assign hs      = hs0 | hs1;
  assign hs_data = hs1 ? req1_data : req0_data;

  // det_out for bit k arrives DET_LAT cycles after the bit was driven.
  assign sample = ((state_q == SHIFT) || (state_q == DRAIN)) && (int'(cnt_q) >= DET_LAT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sreg_d      = sreg_q;
    id_d        = id_q;
    hits_d      = hits_q;
    rr_d        = rr_q;
    x_in_d      = 1'b0;
    det_reset_d = 1'b0;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    res_hits_d  = res_hits_q;
    res_last_d  = res_last_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          id_d   = hs1;
          rr_d   = hs1;
          hits_d = '0;
          cnt_d  = '0;
          if (CLR_EN != 0) begin
            state_d     = CLR;
            det_reset_d = 1'b1;
            sreg_d      = hs_data;
          end else begin
            state_d = SHIFT;
            x_in_d  = hs_data[WIDTH-1];
            sreg_d  = {hs_data[WIDTH-2:0], 1'b0};
          end
        end
      end
      CLR: begin
        state_d = SHIFT;
        x_in_d  = sreg_q[WIDTH-1];
        sreg_d  = {sreg_q[WIDTH-2:0], 1'b0};
      end
      SHIFT, DRAIN: begin
        cnt_d = cnt_q + TW'(1);
        if (sample)
          hits_d = hits_q + CNT_W'(det_out != 2'b00);
        if (state_q == SHIFT) begin
          if (cnt_q == LAST_SHIFT) begin
            state_d = (DET_LAT > 0) ? DRAIN : DONE;
          end else begin
            x_in_d = sreg_q[WIDTH-1];
            sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
          end
        end
        // Final sample: publish the result so it is visible during DONE.
        if (cnt_q == LAST_SAMPLE) begin
          state_d     = DONE;
          res_valid_d = 1'b1;
          res_id_d    = id_q;
          res_hits_d  = hits_d;
          res_last_d  = det_out;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sreg_q      <= '0;
      id_q        <= 1'b0;
      hits_q      <= '0;
      rr_q        <= 1'b1;
      x_in_q      <= 1'b0;
      det_reset_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_hits_q  <= '0;
      res_last_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sreg_q      <= sreg_d;
      id_q        <= id_d;
      hits_q      <= hits_d;
      rr_q        <= rr_d;
      x_in_q      <= x_in_d;
      det_reset_q <= det_reset_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_hits_q  <= res_hits_d;
      res_last_q  <= res_last_d;
    end
  end

  assign x_in      = x_in_q;
  assign det_reset = det_reset_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_hits  = res_hits_q;
  assign res_last  = res_last_q;
  assign busy      = (state_q != IDLE);

endmodule
